serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first two's-complement subtractor.
// One bit per clock through a single borrow flop; results held until next op.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_sa;
  logic             r_sb;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;

  assign w_d = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_borrow_nxt = (~r_a[0] & r_b[0])
                      | (~(r_a[0] ^ r_b[0]) & r_borrow);
  // Result fills from the MSB end so it is aligned after WIDTH shifts
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_borrow   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_sa     <= a[WIDTH-1];
            r_sb     <= b[WIDTH-1];
            busy     <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res    <= w_res_nxt;
          r_borrow <= w_borrow_nxt;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            diff       <= w_res_nxt;
            borrow_out <= w_borrow_nxt;
            overflow   <= (r_sa != r_sb)
                       && (w_res_nxt[WIDTH-1] != r_sa);
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Directed cases plus random operands against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic
  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'(x) - int'(y);
    return W'(r & ((1 << W) - 1));
  endfunction

  function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = sval(x) - sval(y);
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  // Drives one start pulse; returns negedges from accept to done and busy count
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1;
    a = xa;
    b = xb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 1;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, diff, borrow_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=0",
               {busy, done, diff, borrow_out, overflow});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, nb;
    do_op(8'h5A, 8'h23, lat, nb);
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL basic_latency got=%0d want=9", lat);
    end
    n_checks++;
    if (nb !== 8) begin
      n_fail++;
      $display("FAIL basic_busy_cycles got=%0d want=8", nb);
    end
    n_checks++;
    if ({diff, borrow_out, overflow} !== {8'h37, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result got=%h/%b/%b want=37/0/0",
               diff, borrow_out, overflow);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [3] = '{8'h10, 8'h80, 8'h7F};
    logic [W-1:0] tb [3] = '{8'h20, 8'h01, 8'hFF};
    logic [W-1:0] ed [3] = '{8'hF0, 8'h7F, 8'h80};
    logic         eb [3] = '{1'b1, 1'b0, 1'b1};
    logic         eo [3] = '{1'b0, 1'b1, 1'b1};
    int lat, nb;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], lat, nb);
      n_checks++;
      if (lat !== 9 || {diff, borrow_out, overflow} !== {ed[i], eb[i], eo[i]}) begin
        n_fail++;
        $display("FAIL directed_%0d got lat=%0d %h/%b/%b want lat=9 %h/%b/%b",
                 i, lat, diff, borrow_out, overflow, ed[i], eb[i], eo[i]);
      end
    end
  endtask

  task automatic test_hold_ignore;
    int lat;
    logic [W-1:0] prev;
    prev = diff;
    @(negedge clk);
    start = 1'b1;
    a = 8'h33;
    b = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (diff !== prev) begin
      n_fail++;
      $display("FAIL hold_during_run got=%h want=%h", diff, prev);
    end
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (!done || {diff, borrow_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL ignore_start got done=%b %h/%b/%b want 1 00/0/0",
               done, diff, borrow_out, overflow);
    end
    lat = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy || diff !== 8'h00) lat++;
    end
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL hold_after_done got=%0d bad cycles want=0", lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, nb;
    @(negedge clk);
    start = 1'b1;
    a = 8'h5A;
    b = 8'h23;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, diff, borrow_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear got=%b want=0",
               {busy, done, diff, borrow_out, overflow});
    end
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done || busy) lat++;
    end
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done got=%0d bad cycles want=0", lat);
    end
    do_op(8'h01, 8'h02, lat, nb);
    n_checks++;
    if (lat !== 9 || diff !== 8'hFF || borrow_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_after got lat=%0d %h/%b want 9 FF/1",
               lat, diff, borrow_out);
    end
  endtask

  task automatic test_random;
    int lat, nb;
    logic [W-1:0] xa, xb;
    for (int i = 0; i < 40; i++) begin
      xa = W'($urandom);
      xb = (i % 8 == 0) ? xa : W'($urandom);
      do_op(xa, xb, lat, nb);
      n_checks++;
      if (lat !== 9 || diff !== m_diff(xa, xb) || borrow_out !== m_borrow(xa, xb)
          || overflow !== m_ovf(xa, xb)) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h got lat=%0d %h/%b/%b want 9 %h/%b/%b",
                 i, xa, xb, lat, diff, borrow_out, overflow,
                 m_diff(xa, xb), m_borrow(xa, xb), m_ovf(xa, xb));
      end
    end
  endtask

  task automatic test_back_to_back;
    int t, t1, t2, cnt;
    @(negedge clk);
    start = 1'b1;
    a = 8'h00;
    b = 8'h01;
    t = 0;
    t1 = -1;
    t2 = -1;
    cnt = 0;
    while (cnt < 2 && t < 60) begin
      @(negedge clk);
      t++;
      if (done) begin
        if (cnt == 0) t1 = t;
        else t2 = t;
        cnt++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (cnt !== 2 || (t2 - t1) !== W + 2) begin
      n_fail++;
      $display("FAIL back_to_back got dones=%0d interval=%0d want 2/%0d",
               cnt, t2 - t1, W + 2);
    end
    n_checks++;
    if ({diff, borrow_out, overflow} !== {8'hFF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL back_to_back_result got=%h/%b/%b want FF/1/0",
               diff, borrow_out, overflow);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_hold_ignore();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
